// File: rtl/dot_accumulator_pkg.sv
// Shared definitions for the dot-product group accumulator:
// FSM state encoding and default widths.
package dot_accumulator_pkg;

   localparam int ACC_W_DEF = 16;
   localparam int CNT_W_DEF = 8;
   localparam int DATA_W    = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/dot_accumulator_if.sv
// Element input stream and group-summary output stream of the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface dot_accumulator_if
   import dot_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic [DATA_W-1:0] out_max;
   logic              out_sat;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_max, out_sat
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_max, out_sat
   );

endinterface

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags when the sum
// does not fit in W bits.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] wide;

   assign wide = {1'b0, a} + {1'b0, b};
   assign ovf  = wide[W];
   assign sum  = ovf ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates a group of dot-product results (terminated by in_last) into a
// saturating sum, a saturating element count and a running maximum, then
// holds the summary until the consumer takes it.
module dot_accumulator
   import dot_accumulator_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   dot_accumulator_if.slave  bus
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;

   logic [ACC_W-1:0]  sum_q;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] max_q;
   logic              sat_q;

   logic [ACC_W-1:0]  sum_add;
   logic              sum_ovf;
   logic [CNT_W-1:0]  count_add;
   logic              count_ovf;

   // HOLD stalls the input so a new group cannot start before the summary
   // has been taken.
   assign bus.in_ready  = (state != HOLD);
   assign bus.out_valid = (state == HOLD);
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.out_sum   = sum_q;
   assign bus.out_count = count_q;
   assign bus.out_max   = max_q;
   assign bus.out_sat   = sat_q;

   sat_add #(.W(ACC_W)) u_sum_add (
      .a   (sum_q),
      .b   (ACC_W'(bus.in_data)),
      .sum (sum_add),
      .ovf (sum_ovf)
   );

   sat_add #(.W(CNT_W)) u_count_add (
      .a   (count_q),
      .b   (CNT_W'(1)),
      .sum (count_add),
      .ovf (count_ovf)
   );

   // State register; reset wins over any accept or out_ready on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking (<=) for every register so all flops sample
      // pre-edge values regardless of process ordering.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: accepts advance the group, out_ready releases HOLD.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch
      // is inferred.
      state_nxt = state;
      case (state)
         IDLE, ACCUM: if (accept) state_nxt = bus.in_last ? HOLD : ACCUM;
         HOLD:        if (bus.out_ready) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Datapath: load on the first element of a group, accumulate afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q   <= '0;
         count_q <= '0;
         max_q   <= '0;
         sat_q   <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            sum_q   <= ACC_W'(bus.in_data);
            count_q <= CNT_W'(1);
            max_q   <= bus.in_data;
            sat_q   <= 1'b0;
         end else begin
            sum_q   <= sum_add;
            count_q <= count_add;
            if (bus.in_data > max_q) max_q <= bus.in_data;
            sat_q   <= sat_q | sum_ovf | count_ovf;
         end
      end
   end

endmodule
